pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter CW, default 8: width of the length input and the internal counter.
REQ-002 Parameter GAP, default 2: number of forced-low cycles after each pulse; the range is 0 to 15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  single-cycle request for a pulse, sampled on every rising edge.
REQ-006 len  input  CW  pulse length in cycles; sampled only in the cycle a tick is accepted.
REQ-007 retrig_en  input  1  when 1, a tick during an active pulse restarts the length count.
REQ-008 level  output  1  stretched pulse; registered (Moore).
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 dropped  output  1  registered one-cycle flag: a tick was ignored in the previous cycle.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, HIGH, HOLD; level SHALL be 1 only in HIGH.
REQ-012 In IDLE, tick=1 with len!=0 SHALL move to HIGH and load the counter with len-1.
REQ-013 An accepted tick at edge t SHALL produce level=1 on cycles t+1 through t+len exactly (latency 1, width len).
REQ-014 In IDLE, tick=1 with len=0 SHALL be ignored and SHALL assert dropped on the next cycle.
REQ-015 In HIGH with tick=0, the counter SHALL decrement every cycle.
REQ-016 In HIGH with counter=0 and no accepted retrigger, the FSM SHALL go to HOLD if GAP>0, else to IDLE.
REQ-017 In HIGH, tick=1 with retrig_en=1 and len!=0 SHALL reload the counter with len-1 and stay in HIGH; level then stays high through cycle r+len, where r is the retrigger edge.
REQ-018 In HIGH, tick=1 with retrig_en=0 or len=0 SHALL be ignored and SHALL assert dropped; this includes the final HIGH cycle.
REQ-019 HOLD SHALL last exactly GAP cycles with level=0, then return to IDLE; every tick during HOLD SHALL assert dropped.
REQ-020 With GAP=0, level SHALL still be low for at least one cycle between consecutive pulses, since the IDLE cycle follows HIGH.
REQ-021 len SHALL be treated as unsigned; the maximum pulse is 2^CW-1 cycles; the counter SHALL never wrap below 0.
REQ-022 A change of len while in HIGH or HOLD SHALL have no effect unless a retrigger is accepted.
REQ-023 dropped SHALL be high for exactly one cycle per ignored tick; consecutive ignored ticks SHALL give consecutive high cycles.

Reset
REQ-024 reset=1 at a rising edge SHALL force state=IDLE, counter=0, level=0, busy=0, dropped=0, regardless of the current state.
REQ-025 A tick in the same cycle as reset SHALL be ignored and SHALL NOT assert dropped.
REQ-026 Reset asserted mid-pulse SHALL drop level on the next edge, with no HOLD period.

Structure
REQ-027 A shared package pulse_stretcher_pkg SHALL hold the state typedef (IDLE, HIGH, HOLD; binary encoding) and the GAP counter width constant (4).
REQ-028 The length counter SHALL be a sub-module named load_down_counter (ports: clk, reset, load, load_val, dec, count, zero).
REQ-029 The HOLD counter SHALL be a separate 4-bit register inside pulse_stretcher.

Verification
REQ-030 Bench: reset, then tick at edge 5 with len=4 -> level high on cycles 6-9, busy high 6-11 (GAP=2), dropped always 0.
REQ-031 Bench: len=6, retrig_en=1, retrigger tick at cycle 3 of the pulse with len=5 -> level stays high continuously until 5 cycles after the retrigger edge.
REQ-032 Bench: retrig_en=0, ticks during HIGH, on the last HIGH cycle, and during HOLD -> each gives a one-cycle dropped; pulse width is unchanged.
REQ-033 Bench: tick with len=0 in IDLE -> level stays 0, busy stays 0, dropped=1 for one cycle.
REQ-034 Bench: GAP=0, len=1, tick every other cycle -> level alternates 1,0; no ticks dropped.
REQ-035 Bench: reset asserted in the 3rd cycle of a len=10 pulse, together with a tick -> next cycle level=0, busy=0, dropped=0.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_stretcher_pkg;

    // Binary-encoded controller state; level is driven only in HIGH.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Width of the forced-low gap counter; bounds GAP to 0..15.
    localparam int GAP_CW = 4;

endpackage

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down-counter that saturates at zero.
// Latency: load/dec take effect on the next rising edge; zero is combinational from count.
// Backpressure: none; load has priority over dec.
// Ports: clk, reset (sync, active-high), load/load_val (parallel load),
//        dec (decrement request), count (current value), zero (count == 0).
module load_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            // Guarded so the count can never wrap below zero.
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle tick into a level pulse of len cycles, followed by GAP forced-low cycles.
// Latency: level rises one cycle after the accepted tick and stays high for exactly len cycles.
// Backpressure: none; ticks that cannot be accepted are discarded and flagged on dropped one cycle later.
// Ports: clk, reset (sync, active-high), tick (pulse request), len (pulse length, sampled on accept),
//        retrig_en (allow restart during HIGH), level (stretched pulse), busy (not IDLE),
//        dropped (a tick was ignored in the previous cycle).
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CW  = 8,
    parameter int GAP = 2    // 0..15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic [CW-1:0] len,
    input  logic          retrig_en,
    output logic          level,
    output logic          busy,
    output logic          dropped
);

    localparam logic [GAP_CW-1:0] HOLD_LAST = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    state_t              state;
    state_t              state_nxt;
    logic [GAP_CW-1:0]   hold_cnt;
    logic [CW-1:0]       cnt;
    logic                cnt_zero;
    logic                len_nz;
    logic                start_ok;
    logic                retrig_ok;
    logic                accept;
    logic                level_nxt;
    logic                busy_nxt;
    logic                dropped_nxt;

    assign len_nz    = (len != '0);
    assign start_ok  = (state == IDLE) && tick && len_nz;
    assign retrig_ok = (state == HIGH) && tick && retrig_en && len_nz;
    assign accept    = start_ok || retrig_ok;

    // Counter holds the number of HIGH cycles still to come after the current one.
    load_down_counter #(
        .W (CW)
    ) u_len_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (len - CW'(1)),
        .dec      ((state == HIGH) && !retrig_ok),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = HIGH;
            end
            HIGH: begin
                if (!retrig_ok && cnt_zero) state_nxt = (GAP > 0) ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gap counter: loaded with GAP-1 on entry to HOLD, leaves HOLD once it reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if ((state == HIGH) && (state_nxt == HOLD)) begin
            hold_cnt <= HOLD_LAST;
        end else if ((state == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Output logic: decoded from the next state so the outputs leave a flop.
    always_comb begin
        level_nxt   = (state_nxt == HIGH);
        busy_nxt    = (state_nxt != IDLE);
        dropped_nxt = tick && !accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level   <= 1'b0;
            busy    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            level   <= level_nxt;
            busy    <= busy_nxt;
            dropped <= dropped_nxt;
        end
    end

    // IDLE is only ever reached with the length count exhausted or cleared.
    a_idle_cnt_zero: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE) |-> (cnt == '0));

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] len = 8'd0;
    logic       retrig_en = 1'b0;

    logic level_a, busy_a, dropped_a;   // GAP = 2
    logic level_b, busy_b, dropped_b;   // GAP = 0

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.CW(8), .GAP(2)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .len       (len),
        .retrig_en (retrig_en),
        .level     (level_a),
        .busy      (busy_a),
        .dropped   (dropped_a)
    );

    pulse_stretcher #(.CW(8), .GAP(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .len       (len),
        .retrig_en (retrig_en),
        .level     (level_b),
        .busy      (busy_b),
        .dropped   (dropped_b)
    );

    // One row = inputs sampled at an edge + outputs expected right after that edge.
    typedef struct {
        logic       rst;
        logic       tck;
        logic [7:0] ln;
        logic       ret;
        logic       use_b;
        logic       lvl;
        logic       bsy;
        logic       drp;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic rst, logic tck, logic [7:0] ln, logic ret,
                                logic use_b, logic lvl, logic bsy, logic drp);
        vec_t v;
        v.rst = rst; v.tck = tck; v.ln = ln; v.ret = ret; v.use_b = use_b;
        v.lvl = lvl; v.bsy = bsy; v.drp = drp;
        return v;
    endfunction

    task automatic add(logic rst, logic tck, logic [7:0] ln, logic ret,
                       logic use_b, logic lvl, logic bsy, logic drp, int reps);
        for (int k = 0; k < reps; k++) tbl.push_back(mk(rst, tck, ln, ret, use_b, lvl, bsy, drp));
    endtask

    task automatic chk(string nm, int idx, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        int   width;
        int   pend_w;

        // Reset, with and without a coincident tick.
        add(1, 0, 0,  0, 0, 0, 0, 0, 2);
        add(1, 1, 4,  0, 0, 0, 0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 0, 0, 4);
        // Basic pulse, len=4, GAP=2: 4 high, 2 hold, then idle.
        add(0, 1, 4,  0, 0, 1, 1, 0, 1);
        add(0, 0, 4,  0, 0, 1, 1, 0, 3);
        add(0, 0, 0,  0, 0, 0, 1, 0, 2);
        add(0, 0, 0,  0, 0, 0, 0, 0, 2);
        // Retrigger: len=6, then len=5 on the third pulse edge; len changes without tick are ignored.
        add(0, 1, 6,  1, 0, 1, 1, 0, 1);
        add(0, 0, 200,1, 0, 1, 1, 0, 2);
        add(0, 1, 5,  1, 0, 1, 1, 0, 1);
        add(0, 0, 9,  1, 0, 1, 1, 0, 4);
        add(0, 0, 0,  0, 0, 0, 1, 0, 2);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1);
        // retrig_en=0: ticks in HIGH, on the last HIGH cycle and throughout HOLD are dropped.
        add(0, 1, 3,  0, 0, 1, 1, 0, 1);
        add(0, 1, 7,  0, 0, 1, 1, 1, 1);
        add(0, 0, 0,  0, 0, 1, 1, 0, 1);
        add(0, 1, 3,  0, 0, 0, 1, 1, 2);
        add(0, 1, 3,  0, 0, 0, 0, 1, 1);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1);
        // len=0 in IDLE, and len=0 retrigger in HIGH.
        add(0, 1, 0,  0, 0, 0, 0, 1, 1);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1);
        add(0, 1, 2,  1, 0, 1, 1, 0, 1);
        add(0, 1, 0,  1, 0, 1, 1, 1, 1);
        add(0, 0, 0,  0, 0, 0, 1, 0, 2);
        add(0, 0, 0,  0, 0, 0, 0, 0, 1);
        // GAP=0 instance: len=1 every other cycle alternates level, nothing dropped.
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 1, 0, 1, 1, 1, 0, 1);
            add(0, 0, 0, 0, 1, 0, 0, 0, 1);
        end
        add(0, 0, 0,  0, 1, 0, 0, 0, 3);
        // Reset with a tick during the third cycle of a len=10 pulse.
        add(0, 1, 10, 0, 0, 1, 1, 0, 1);
        add(0, 0, 10, 0, 0, 1, 1, 0, 2);
        add(1, 1, 5,  0, 0, 0, 0, 0, 1);
        add(0, 0, 0,  0, 0, 0, 0, 0, 2);

        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst; tick = tbl[i].tck; len = tbl[i].ln; retrig_en = tbl[i].ret;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (e.use_b) begin
                chk("level_g0",   i, level_b,   e.lvl);
                chk("busy_g0",    i, busy_b,    e.bsy);
                chk("dropped_g0", i, dropped_b, e.drp);
            end else begin
                chk("level",   i, level_a,   e.lvl);
                chk("busy",    i, busy_a,    e.bsy);
                chk("dropped", i, dropped_a, e.drp);
            end
        end

        // Maximum length pulse: exactly 255 high cycles, no wrap, then HOLD.
        @(negedge clk);
        tick = 1'b1; len = 8'd255; retrig_en = 1'b0;
        pend_w = 255;
        @(posedge clk);
        #1;
        @(negedge clk);
        tick = 1'b0; len = 8'd0;
        width = 0;
        while (level_a === 1'b1 && width < 300) begin
            width++;
            @(posedge clk);
            #1;
        end
        chk("max_width", 255, (width == pend_w), 1'b1);
        if (width != pend_w) $display("FAIL max_width: got %0d cycles expected %0d", width, pend_w);
        chk("max_hold_busy", 255, busy_a, 1'b1);
        chk("max_dropped", 255, dropped_a, 1'b0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
